// File: rtl/pq_pkg.sv
// Shared types and helpers for the priority-queue access controller.
package pq_pkg;

    // Default key width of the attached priority queues.
    localparam int PQ_DATA_WIDTH = 16;

    typedef logic [PQ_DATA_WIDTH-1:0] key_t;

    // Command issued to the queue in a given cycle.
    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } op_e;

    // Bits needed to count 0..max_value inclusive (at least one bit).
    function automatic int occ_width(input int max_value);
        int w;
        w = $clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pq_result_slot.sv
// Single-entry valid/ready holding register for popped keys.
// 'reserve' marks a pop whose key has not been captured yet; while it is
// high the slot reports itself as not free so no second pop can be issued.
module pq_result_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_data,
    input  logic             reserve,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    // Free when empty or emptying this cycle, and no pop is in flight.
    assign free = (!valid || ready) && !reserve;

    // Capture the queue root on a read command; clear on consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            data  <= capture_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pq_access_ctrl.sv
// Requester-side front end for the hardware priority queues.
// Turns a push stream and a pop-request stream into single-cycle queue
// commands (push, pop, or a merged replace), spaces commands by OP_GAP idle
// cycles, tracks occupancy and returns popped keys on a result stream.
//
// Handshake rule for every stream: a transfer happens in a cycle where
// valid and ready are both 1. Ready may depend combinationally on valid;
// a producer keeps valid and data stable until the transfer happens.
module pq_access_ctrl
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = PQ_DATA_WIDTH,
    parameter int QUEUE_SIZE = 28,
    parameter int OP_GAP     = 1
) (
    input  logic                               CLK,
    input  logic                               RSTn,
    input  logic                               s_push_valid,
    output logic                               s_push_ready,
    input  logic [DATA_WIDTH-1:0]              s_push_data,
    input  logic                               s_pop_valid,
    output logic                               s_pop_ready,
    output logic                               m_pop_valid,
    input  logic                               m_pop_ready,
    output logic [DATA_WIDTH-1:0]              m_pop_data,
    output logic                               pq_wrt,
    output logic                               pq_read,
    output logic [DATA_WIDTH-1:0]              pq_data,
    input  logic                               pq_full,
    input  logic                               pq_empty,
    input  logic [DATA_WIDTH-1:0]              pq_o_data,
    output logic [occ_width(QUEUE_SIZE)-1:0]   occupancy,
    output logic                               err
);

    localparam int OCC_W = occ_width(QUEUE_SIZE);
    localparam int GAP_W = occ_width(OP_GAP);
    localparam logic [OCC_W-1:0] CAPACITY = OCC_W'(QUEUE_SIZE);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(OP_GAP);

    logic [OCC_W-1:0] count;
    logic [GAP_W-1:0] gap_cnt;
    op_e              op;
    logic             pop_ok;
    logic             push_issue;
    logic             pop_issue;
    logic             slot_free;
    logic             cmd_d1;
    logic             cmd_d2;
    logic             quiet;
    logic             status_mismatch;

    // Result register; a pop in flight (pq_read high) reserves it.
    pq_result_slot #(
        .WIDTH (DATA_WIDTH)
    ) u_slot (
        .clk          (CLK),
        .rst_n        (RSTn),
        .capture      (pq_read),
        .capture_data (pq_o_data),
        .reserve      (pq_read),
        .ready        (m_pop_ready),
        .valid        (m_pop_valid),
        .data         (m_pop_data),
        .free         (slot_free)
    );

    // Accept arbiter: replace beats push beats pop; nothing inside the gap
    // window or while reset is asserted.
    always_comb begin
        op     = OP_NONE;
        pop_ok = s_pop_valid && (count != '0) && slot_free;
        if (RSTn && (gap_cnt == '0)) begin
            if (s_push_valid && pop_ok) begin
                op = OP_REPLACE;
            end else if (s_push_valid && (count < CAPACITY)) begin
                op = OP_PUSH;
            end else if (pop_ok) begin
                op = OP_POP;
            end
        end
    end

    assign push_issue   = (op == OP_PUSH) || (op == OP_REPLACE);
    assign pop_issue    = (op == OP_POP)  || (op == OP_REPLACE);
    assign s_push_ready = push_issue;
    assign s_pop_ready  = pop_issue;
    assign occupancy    = count;

    // Gap counter: reload on every accept, then count down to zero.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            gap_cnt <= '0;
        end else if (op != OP_NONE) begin
            gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Element count follows accepts; a replace leaves it unchanged.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else begin
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered one-cycle queue commands; write data holds between pushes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pq_wrt  <= 1'b0;
            pq_read <= 1'b0;
            pq_data <= '0;
        end else begin
            pq_wrt  <= push_issue;
            pq_read <= pop_issue;
            if (push_issue) begin
                pq_data <= s_push_data;
            end
        end
    end

    // Command history so status is only compared once the queue has settled.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cmd_d1 <= 1'b0;
            cmd_d2 <= 1'b0;
        end else begin
            cmd_d1 <= pq_wrt || pq_read;
            cmd_d2 <= cmd_d1;
        end
    end

    assign quiet           = !pq_wrt && !pq_read && !cmd_d1 && !cmd_d2;
    assign status_mismatch = (pq_empty != (count == '0)) ||
                             (pq_full  != (count == CAPACITY));

    // Sticky flag: queue status disagrees with our own count while idle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            err <= 1'b0;
        end else if (quiet && status_mismatch) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/pq_access_ctrl.md
Name: pq_access_ctrl

Overview:
- Requester-side front end for the team's hardware priority queues: hybrid register/BRAM tree, pipelined BRAM tree, or anything else that exposes the i_wrt/i_read/i_data and o_full/o_empty/o_data command interface.
- Converts a valid/ready push stream and a pop-request stream into single-cycle queue commands. Merges a simultaneous push and pop into a replace.
- Enforces the minimum inter-command spacing the pipelined queue needs, tracks occupancy, and returns popped values on a valid/ready result stream.

Parameters:
- DATA_WIDTH, 16, key width; larger key means higher priority.
- QUEUE_SIZE, 28, capacity of the attached queue.
- OP_GAP, 1, idle cycles required between consecutive queue commands (0 allows back-to-back commands).

Ports:
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- s_push_valid  in  1  push request.
- s_push_ready  out  1  push accepted this cycle.
- s_push_data  in  DATA_WIDTH  key to insert.
- s_pop_valid  in  1  pop request.
- s_pop_ready  out  1  pop accepted this cycle.
- m_pop_valid  out  1  popped key available.
- m_pop_ready  in  1  consumer takes the popped key.
- m_pop_data  out  DATA_WIDTH  popped key.
- pq_wrt  out  1  queue write command.
- pq_read  out  1  queue read command.
- pq_data  out  DATA_WIDTH  queue write data.
- pq_full  in  1  queue full status.
- pq_empty  in  1  queue empty status.
- pq_o_data  in  DATA_WIDTH  queue root (current maximum).
- occupancy  out  $clog2(QUEUE_SIZE+1)  controller's element count.
- err  out  1  sticky status-mismatch flag.

Behaviour:
- Clock and reset: one clock, CLK; reset RSTn is asynchronous, active-low.
- Reset values: all outputs 0. Internal state also cleared: count 0, gap_cnt 0, result slot empty, in-flight flags 0.
- Reset mid-operation: any in-flight command or result is discarded. The attached queue shares RSTn, so both sides restart empty.
- Issue window: an accept may happen only when gap_cnt==0. On any accept, gap_cnt loads OP_GAP, then decrements by 1 each cycle while nonzero.
- slot_free: the result register is empty, or it is being drained this cycle (m_pop_valid && m_pop_ready), and no pop is already in flight.
- Accept decision, evaluated combinationally in a cycle with gap_cnt==0, in priority order:
  a. REPLACE when push valid, pop valid, count>0 and slot_free. Both readies are 1. count is unchanged, including at count==QUEUE_SIZE.
  b. PUSH when push valid and count<QUEUE_SIZE. s_push_ready=1, count+1. A pop that is also valid stalls, which covers count==0 and a busy result slot.
  c. POP when pop valid, count>0 and slot_free. s_pop_ready=1, count-1.
  d. Otherwise both readies are 0.
- Readies are never asserted when gap_cnt!=0.
- Command timing: accept in cycle t drives the registered pq_wrt/pq_read/pq_data in cycle t+1 for exactly one cycle.
  - PUSH: wrt=1, read=0.
  - POP: wrt=0, read=1.
  - REPLACE: both 1.
  - pq_data is held at its last value when no push is issued.
- Result capture: in the cycle pq_read=1, pq_o_data (the root before the operation) is captured into the result register. m_pop_valid rises in t+2, so accept-to-result latency is 2 cycles. REPLACE therefore has pop-then-push semantics and returns the old root.
- m_pop_valid/m_pop_data hold until m_pop_ready. The result slot is a single entry; back-pressure stalls further pops only, and pushes continue.
- occupancy equals count. It updates at the accept edge, so it is valid in t+1.
- err check: evaluated only when no command has been issued for the previous 2 cycles.
  - Sets when pq_empty != (count==0) or pq_full != (count==QUEUE_SIZE).
  - Stays set until reset.
- Zero keys are legal. An empty queue is never sent a REPLACE, so the queue's zero-key special case is never exercised.

Decomposition:
- Shared package pq_pkg holds:
  - the op_e enum {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE};
  - the key_t typedef (logic [DATA_WIDTH-1:0]);
  - the function computing the occupancy width.
- One natural sub-module: pq_result_slot, the single-entry valid/ready holding register with a reservation input.
- Gap counter and accept arbiter stay inline.

Test Plan:
- Spacing and occupancy: OP_GAP=1, push 5, 9, 3 held valid from cycle 0 -> pq_wrt pulses in cycles 1, 3 and 5 with pq_data 5, 9, 3; occupancy=3 after cycle 5.
- Pop latency: pop with queue {9,5,3} accepted in cycle c -> pq_read in c+1; m_pop_valid=1 with m_pop_data=9 in c+2; occupancy 2.
- Replace: push 7 and pop together with queue {5,3} -> single cycle with pq_wrt=pq_read=1; returned key 5; occupancy stays 2; next pop returns 7.
- Capacity: fill to 28 -> s_push_ready stays 0; push+pop together is accepted as REPLACE; occupancy holds at 28; err remains 0.
- Empty queue and back-pressure:
  - Pop on an empty queue -> s_pop_ready=0 and no pq command.
  - Push+pop on an empty queue -> PUSH only; the pop is accepted at the next window.
  - m_pop_ready held 0 -> second pop stalls while pushes proceed.
- Reset and mismatch:
  - Assert RSTn mid-command -> all outputs 0 at once; after release, a push is accepted within 1 cycle.
  - Force pq_empty=1 with count=2 while idle -> err=1 and stays set.
